router_port_arbiter: RTL and testbench
======================================

# router_port_arbiter

Per-output-port round-robin arbiter for the 16-port serial router. Each input port's header decoder raises a request carrying the decoded destination address. This block grants each output port to at most one input port at a time and holds the grant until that input signals end of frame. A per-output watchdog reclaims ports whose owner never releases. It sits between the input header decoders and the output-port datapath muxes, and drives the mux select for every output.

## Interface
Parameters:
- NUM_PORTS, 16, number of input and output ports (power of two, 2..16)
- ADDR_W, 4, destination address width, equal to log2(NUM_PORTS)
- TIMEOUT, 1024, maximum cycles an output may stay owned without release; 0 disables the watchdog

Ports:
- clock  in  1  sole clock, rising edge
- reset  in  1  synchronous, active-high reset
- req  in  NUM_PORTS  req[i] high while input i has a decoded header and wants its destination
- req_dest  in  NUM_PORTS*ADDR_W  destination of input i in bits [i*ADDR_W +: ADDR_W]; stable while req[i] is high
- release  in  NUM_PORTS  one-cycle pulse from input i at end of its frame
- grant  out  NUM_PORTS  grant[i] high while input i owns its destination output
- out_busy  out  NUM_PORTS  out_busy[o] high while output o is owned
- out_sel  out  NUM_PORTS*ADDR_W  owning input index for output o in bits [o*ADDR_W +: ADDR_W]; valid only when out_busy[o] is high
- timeout_err  out  NUM_PORTS  one-cycle pulse on output o when its watchdog fires

## Operation
- Each output o has a two-state FSM (IDLE, BUSY), a round-robin pointer rr_ptr[o] of ADDR_W bits, an owner register, and a watchdog counter.
- Candidate set for output o: all inputs i with req[i]=1, req_dest[i]=o, and grant[i]=0.
- IDLE with a non-empty candidate set:
  - Select the first candidate at or after rr_ptr[o], scanning ascending and wrapping NUM_PORTS-1 to 0.
  - Next cycle: state BUSY, owner = i, grant[i]=1, out_busy[o]=1, out_sel[o]=i, rr_ptr[o]=(i+1) mod NUM_PORTS, watchdog cleared.
- IDLE with an empty candidate set: hold state; rr_ptr[o] unchanged.
- BUSY:
  - release[owner]=1: next cycle state IDLE, grant[owner]=0, out_busy[o]=0.
  - A release from a non-owner input is ignored.
  - Deassertion of req[owner] does not free the output; only release or the watchdog does.
- Watchdog (TIMEOUT>0):
  - The counter increments each BUSY cycle without release[owner].
  - When the count reaches TIMEOUT with no release in that cycle, the output is freed exactly as on release.
  - timeout_err[o] pulses for one cycle, aligned with out_busy[o] falling.
- Any input targets a single destination, so at most one output can grant a given input. grant[i] is the OR over outputs of (BUSY and owner=i).
- No arbitration occurs in a BUSY cycle, including the release cycle.

## Timing
- Reset (synchronous, dominant over all other inputs): all FSMs IDLE; grant, out_busy, out_sel, timeout_err and all rr_ptr, owner and watchdog registers are 0. Outputs show these values in the cycle after reset is sampled high.
- Reset mid-frame: all grants drop in the next cycle. Pending requests are re-arbitrated from rr_ptr=0 in the cycle after reset deasserts.
- Request-to-grant latency: 1 cycle (req sampled at edge t, grant visible after edge t+1) when the output is IDLE.
- Release-to-free latency: 1 cycle. The earliest new grant on the same output comes 2 cycles after the release edge, which guarantees one idle cycle between frames.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- Simultaneous requests to different outputs are granted in the same cycle, independently.
- Release and req from the same input in the same cycle: the release is honoured. The input is eligible again once its grant is 0, but rr_ptr has already advanced past it.

## Test plan
- Reset check: assert reset for 2 cycles with random req -> grant=0, out_busy=0, out_sel=0, timeout_err=0 in the cycle after each sampled reset.
- Single request: req[3]=1, req_dest[3]=5 at cycle 10 -> grant[3]=1, out_busy[5]=1, out_sel[5]=3 from cycle 11; release[3] at cycle 20 -> grant[3]=0, out_busy[5]=0 at cycle 21.
- Round robin: inputs 0, 4 and 9 all request output 2 continuously, each releasing 3 cycles after its grant -> grant order 0, 4, 9, 0, with exactly one idle cycle on out_busy[2] between owners.
- Parallel outputs: inputs 1→7, 2→8 and 15→0 request together -> all three grants rise in the same cycle; a release from input 2 frees only output 8.
- Watchdog: TIMEOUT=8, input 6 granted output 1 and never releases -> out_busy[1] falls and timeout_err[1] pulses exactly 8 BUSY cycles after the grant; release[6] pulsed while input 6 is not the owner has no effect.
- Mid-frame reset and wrap: advance rr_ptr[3] to 15, then input 14 and input 0 request output 3 -> input 0 is granted first (wrap-around). A reset during that grant drops grant[0] in the next cycle, and re-arbitration after reset grants input 0 again (rr_ptr back to 0).

Source files
------------

// File: rtl/router_port_arbiter.sv
// Per-output round-robin arbiter for the serial router: each output grants one
// input until that input signals end of frame or the output's watchdog expires.
module router_port_arbiter #(
  parameter int NUM_PORTS = 16,
  parameter int ADDR_W    = 4,
  parameter int TIMEOUT   = 1024
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_PORTS-1:0]        req,
  input  logic [NUM_PORTS*ADDR_W-1:0] req_dest,
  input  logic [NUM_PORTS-1:0]        frame_release,
  output logic [NUM_PORTS-1:0]        grant,
  output logic [NUM_PORTS-1:0]        out_busy,
  output logic [NUM_PORTS*ADDR_W-1:0] out_sel,
  output logic [NUM_PORTS-1:0]        timeout_err
);

  // state | meaning
  // IDLE  | output free, arbitrating among requesters each cycle
  // BUSY  | output owned by owner_q, waiting for release or watchdog expiry

  // Watchdog is a down-counter loaded at grant; expiry is the zero terminal count.
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] WD_LOAD = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t              state_q [NUM_PORTS];
  state_t              state_d [NUM_PORTS];
  logic [ADDR_W-1:0]   rr_q    [NUM_PORTS];
  logic [ADDR_W-1:0]   rr_d    [NUM_PORTS];
  logic [ADDR_W-1:0]   owner_q [NUM_PORTS];
  logic [ADDR_W-1:0]   owner_d [NUM_PORTS];
  logic [CNT_W-1:0]    wd_q    [NUM_PORTS];
  logic [CNT_W-1:0]    wd_d    [NUM_PORTS];
  logic [NUM_PORTS-1:0] tmo_q;
  logic [NUM_PORTS-1:0] tmo_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int o = 0; o < NUM_PORTS; o++) begin
        state_q[o] <= IDLE;
        rr_q[o]    <= '0;
        owner_q[o] <= '0;
        wd_q[o]    <= '0;
      end
      tmo_q <= '0;
    end else begin
      for (int o = 0; o < NUM_PORTS; o++) begin
        state_q[o] <= state_d[o];
        rr_q[o]    <= rr_d[o];
        owner_q[o] <= owner_d[o];
        wd_q[o]    <= wd_d[o];
      end
      tmo_q <= tmo_d;
    end
  end

  // An input targets one destination, so at most one output can claim it.
  always_comb begin
    grant = '0;
    for (int o = 0; o < NUM_PORTS; o++) begin
      if (state_q[o] == BUSY) grant[owner_q[o]] = 1'b1;
    end
  end

  always_comb begin
    out_busy = '0;
    out_sel  = '0;
    for (int o = 0; o < NUM_PORTS; o++) begin
      out_busy[o]                   = (state_q[o] == BUSY);
      out_sel[o*ADDR_W +: ADDR_W]   = owner_q[o];
    end
  end

  assign timeout_err = tmo_q;

  always_comb begin
    logic              found;
    logic [ADDR_W-1:0] idx;
    logic [ADDR_W-1:0] pick;
    tmo_d = '0;
    for (int o = 0; o < NUM_PORTS; o++) begin
      state_d[o] = state_q[o];
      rr_d[o]    = rr_q[o];
      owner_d[o] = owner_q[o];
      wd_d[o]    = wd_q[o];
      found      = 1'b0;
      idx        = '0;
      pick       = '0;
      case (state_q[o])
        IDLE: begin
          // Pointer arithmetic wraps naturally because NUM_PORTS == 2**ADDR_W.
          for (int k = 0; k < NUM_PORTS; k++) begin
            idx = rr_q[o] + ADDR_W'(k);
            if (!found && req[idx] && !grant[idx] &&
                (req_dest[idx*ADDR_W +: ADDR_W] == ADDR_W'(o))) begin
              found = 1'b1;
              pick  = idx;
            end
          end
          if (found) begin
            state_d[o] = BUSY;
            owner_d[o] = pick;
            rr_d[o]    = pick + 1'b1;
            wd_d[o]    = WD_LOAD;
          end
        end
        BUSY: begin
          if (frame_release[owner_q[o]]) begin
            state_d[o] = IDLE;
          end else if (TIMEOUT > 0) begin
            if (wd_q[o] == '0) begin
              state_d[o] = IDLE;
              tmo_d[o]   = 1'b1;
            end else begin
              wd_d[o] = wd_q[o] - 1'b1;
            end
          end
        end
        default: state_d[o] = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_router_port_arbiter.sv
// Bench for router_port_arbiter: directed scenarios plus random traffic, two
// instances (watchdog of 8 cycles and watchdog disabled) checked against a model.
module tb_router_port_arbiter;
  localparam int N  = 16;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [N-1:0]  req;
  logic [N-1:0]  rel;
  logic [N*AW-1:0] req_dest;
  logic [N-1:0]  grant_a, busy_a, tmo_a, grant_b, busy_b, tmo_b;
  logic [N*AW-1:0] sel_a, sel_b;

  int vectors     = 0;
  int miscompares = 0;

  int m_busy  [2][N];
  int m_owner [2][N];
  int m_ptr   [2][N];
  int m_age   [2][N];
  int m_tmo   [2][N];
  int rr_exp  [4] = '{0, 4, 9, 0};

  always #5 clk = ~clk;

  router_port_arbiter #(.NUM_PORTS(N), .ADDR_W(AW), .TIMEOUT(8)) dut_a (
    .clk(clk), .reset(reset), .req(req), .req_dest(req_dest), .frame_release(rel),
    .grant(grant_a), .out_busy(busy_a), .out_sel(sel_a), .timeout_err(tmo_a));

  router_port_arbiter #(.NUM_PORTS(N), .ADDR_W(AW), .TIMEOUT(0)) dut_b (
    .clk(clk), .reset(reset), .req(req), .req_dest(req_dest), .frame_release(rel),
    .grant(grant_b), .out_busy(busy_b), .out_sel(sel_b), .timeout_err(tmo_b));

  function automatic int timeout_of(input int m);
    return (m == 0) ? 8 : 0;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: outputs own a port until release or age limit; free ports scan from ptr.
  task automatic model_step();
    int  g [N];
    bit  found;
    for (int m = 0; m < 2; m++) begin
      if (reset) begin
        for (int o = 0; o < N; o++) begin
          m_busy[m][o] = 0; m_owner[m][o] = 0; m_ptr[m][o] = 0;
          m_age[m][o]  = 0; m_tmo[m][o]   = 0;
        end
      end else begin
        for (int i = 0; i < N; i++) g[i] = 0;
        for (int o = 0; o < N; o++) if (m_busy[m][o] != 0) g[m_owner[m][o]] = 1;
        for (int o = 0; o < N; o++) begin
          m_tmo[m][o] = 0;
          if (m_busy[m][o] != 0) begin
            if (rel[m_owner[m][o]]) m_busy[m][o] = 0;
            else begin
              m_age[m][o]++;
              if (timeout_of(m) > 0 && m_age[m][o] >= timeout_of(m)) begin
                m_busy[m][o] = 0;
                m_tmo[m][o]  = 1;
              end
            end
          end else begin
            found = 0;
            for (int k = 0; k < N; k++) begin
              int i = (m_ptr[m][o] + k) % N;
              if (!found && req[i] && (int'(req_dest[i*AW +: AW]) == o) && g[i] == 0) begin
                found = 1;
                m_busy[m][o] = 1; m_owner[m][o] = i;
                m_ptr[m][o]  = (i + 1) % N; m_age[m][o] = 0;
              end
            end
          end
        end
      end
    end
  endtask

  task automatic check_all();
    logic [N-1:0]    eg, eb, et, og, ob, ot;
    logic [N*AW-1:0] es, os;
    for (int m = 0; m < 2; m++) begin
      eg = '0; eb = '0; et = '0; es = '0;
      og = (m == 0) ? grant_a : grant_b;
      ob = (m == 0) ? busy_a  : busy_b;
      ot = (m == 0) ? tmo_a   : tmo_b;
      os = (m == 0) ? sel_a   : sel_b;
      for (int o = 0; o < N; o++) begin
        et[o] = (m_tmo[m][o] != 0);
        if (m_busy[m][o] != 0) begin
          eb[o] = 1'b1;
          eg[m_owner[m][o]] = 1'b1;
          es[o*AW +: AW] = AW'(m_owner[m][o]);
        end else begin
          os[o*AW +: AW] = '0;
        end
      end
      chk($sformatf("model_grant_%0d", m), og, eg);
      chk($sformatf("model_busy_%0d", m), ob, eb);
      chk($sformatf("model_tmo_%0d", m), ot, et);
      chk($sformatf("model_sel_%0d", m), os, es);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_all();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cycle();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; req = '0; rel = '0; req_dest = '0;

    // Reset dominates random requests.
    for (int k = 0; k < 2; k++) begin
      req = N'($urandom); req_dest = {$urandom, $urandom};
      cycle();
      chk("rst_grant", {grant_a, grant_b}, 0);
      chk("rst_busy", {busy_a, busy_b}, 0);
      chk("rst_sel_a", sel_a, 0);
      chk("rst_sel_b", sel_b, 0);
      chk("rst_tmo", {tmo_a, tmo_b}, 0);
    end
    reset = 1'b0; req = '0;
    repeat (2) cycle();

    // Single request 3 -> 5, released after 10 owned cycles.
    req_dest[3*AW +: AW] = 4'd5; req[3] = 1'b1;
    cycle();
    chk("single_grant", grant_b, 64'h0008);
    chk("single_busy", busy_b, 64'h0020);
    chk("single_sel", sel_b[5*AW +: AW], 3);
    repeat (9) cycle();
    chk("single_hold", grant_b, 64'h0008);
    rel[3] = 1'b1; req[3] = 1'b0;
    cycle();
    rel = '0;
    chk("single_free_grant", grant_b, 0);
    chk("single_free_busy", busy_b, 0);
    do_reset();

    // Round robin among inputs 0, 4, 9 on output 2.
    req_dest[0*AW +: AW] = 4'd2; req_dest[4*AW +: AW] = 4'd2; req_dest[9*AW +: AW] = 4'd2;
    req[0] = 1'b1; req[4] = 1'b1; req[9] = 1'b1;
    cycle();
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("rr_owner%0d", k), grant_b, 64'd1 << rr_exp[k]);
      chk($sformatf("rr_sel%0d", k), sel_b[2*AW +: AW], rr_exp[k]);
      cycle(); cycle();
      rel[rr_exp[k]] = 1'b1;
      cycle();
      rel = '0;
      chk($sformatf("rr_gap%0d", k), busy_b[2], 0);
      cycle();
    end
    req = '0;
    do_reset();

    // Independent outputs granted together; release frees only its own output.
    req_dest[1*AW +: AW] = 4'd7; req_dest[2*AW +: AW] = 4'd8; req_dest[15*AW +: AW] = 4'd0;
    req[1] = 1'b1; req[2] = 1'b1; req[15] = 1'b1;
    cycle();
    chk("par_grant", grant_b, 64'h8006);
    chk("par_busy", busy_b, 64'h0181);
    chk("par_sel", {sel_b[0 +: AW], sel_b[7*AW +: AW], sel_b[8*AW +: AW]}, 64'hF12);
    rel[2] = 1'b1; req[2] = 1'b0;
    cycle();
    rel = '0;
    chk("par_rel_busy", busy_b, 64'h0081);
    chk("par_rel_grant", grant_b, 64'h8002);
    req = '0;
    do_reset();

    // Watchdog: owner 6 never releases on output 1.
    req_dest[6*AW +: AW] = 4'd1; req[6] = 1'b1;
    cycle();
    for (int n = 0; n < 8; n++) begin
      chk($sformatf("wd_busy%0d", n), busy_a[1], 1);
      chk($sformatf("wd_quiet%0d", n), tmo_a[1], 0);
      cycle();
    end
    chk("wd_fire_busy", busy_a[1], 0);
    chk("wd_fire_err", tmo_a, 64'h0002);
    chk("wd_fire_grant", grant_a[6], 0);
    chk("wd_off_busy", busy_b[1], 1);
    req[6] = 1'b0;
    cycle();
    chk("wd_err_pulse", tmo_a[1], 0);
    chk("wd_off_err", tmo_b, 0);
    do_reset();

    // Release from a non-owner is ignored.
    req_dest[10*AW +: AW] = 4'd1; req[10] = 1'b1;
    cycle();
    rel[6] = 1'b1;
    cycle();
    rel = '0;
    chk("nonowner_busy", busy_a[1], 1);
    chk("nonowner_grant", grant_a, 64'h0400);
    req = '0;
    do_reset();

    // Advance rr_ptr[3] to 15, then check wrap and mid-frame reset.
    req_dest[14*AW +: AW] = 4'd3; req[14] = 1'b1;
    cycle();
    rel[14] = 1'b1; req[14] = 1'b0;
    cycle();
    rel = '0;
    cycle();
    req_dest[0 +: AW] = 4'd3; req[0] = 1'b1; req[14] = 1'b1;
    cycle();
    chk("wrap_grant", grant_b, 64'h0001);
    chk("wrap_busy", busy_b[3], 1);
    reset = 1'b1;
    cycle();
    chk("midrst_grant_b", grant_b, 0);
    chk("midrst_grant_a", grant_a, 0);
    reset = 1'b0;
    cycle();
    chk("rearb_grant", grant_b, 64'h0001);
    req = '0;
    do_reset();

    // Random traffic with contention on low outputs and occasional reset.
    for (int c = 0; c < 800; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!req[i]) begin
          if ($urandom_range(3) == 0) begin
            req_dest[i*AW +: AW] = ($urandom_range(1) == 0) ? AW'($urandom_range(3))
                                                            : AW'($urandom_range(N-1));
            req[i] = 1'b1;
          end
        end else if ($urandom_range(15) == 0) begin
          req[i] = 1'b0;
        end
        rel[i] = ($urandom_range(9) == 0);
      end
      reset = ($urandom_range(199) == 0);
      cycle();
    end
    reset = 1'b0; rel = '0; req = '0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
